// File: rtl/clk_div_gen_pkg.sv
// Shared types and constants for the clk_div_gen programmable clock-enable divider.
package clk_div_gen_pkg;
  localparam int DEFAULT_DIV_W = 8;
  localparam int MIN_RATIO     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/clk_div_gen_period_cnt.sv
// Period counter 0..N-1 with wrap flag; the shadow ratio is adopted only on clear or wrap.
module clk_div_gen_period_cnt
  import clk_div_gen_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] shadow_i,
  output logic             wrap_o,
  output logic [DIV_W-1:0] cnt_next_o,
  output logic [DIV_W-1:0] ratio_next_o
);
  localparam logic [DIV_W-1:0] MIN_R = DIV_W'(MIN_RATIO);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] shadow_eff;

  // Ratios 0 and 1 cannot form a period with distinct high and low phases.
  assign shadow_eff = (shadow_i < MIN_R) ? MIN_R : shadow_i;
  assign wrap_o     = (cnt_q == ratio_q - DIV_W'(1));

  always_comb begin
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    if (clr_i) begin
      cnt_d   = '0;
      ratio_d = shadow_eff;
    end else if (en_i) begin
      if (wrap_o) begin
        cnt_d   = '0;
        ratio_d = shadow_eff;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      ratio_q <= MIN_R;
    end else begin
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
    end
  end

  assign cnt_next_o   = cnt_d;
  assign ratio_next_o = ratio_d;
endmodule

// File: rtl/clk_div_gen.sv
// Programmable clock-enable divider with IDLE/RUN/DRAIN control.
// Define CLK_DIV_GEN_DUTY50_EN for a ~50% duty waveform; otherwise clk_div is a one-cycle pulse per period.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             clk_div,
  output logic             en_d,
  output logic             busy,
  output logic             period_done
);
  localparam logic [DIV_W-1:0] MIN_R = DIV_W'(MIN_RATIO);

  state_t           state_q;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             clk_div_q, en_d_q, busy_q, period_done_q;
  logic             wrap;
  logic [DIV_W-1:0] cnt_next, ratio_next;
  logic             phase_next;

  assign shadow_d = load ? div_ratio : shadow_q;

  clk_div_gen_period_cnt #(.DIV_W(DIV_W)) u_period_cnt (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (state_q == ST_IDLE),
    .en_i         (state_q != ST_IDLE),
    .shadow_i     (shadow_d),
    .wrap_o       (wrap),
    .cnt_next_o   (cnt_next),
    .ratio_next_o (ratio_next)
  );

  // Waveform level for the counter position the next cycle will hold.
  always_comb begin
    phase_next = 1'b0;
`ifdef CLK_DIV_GEN_DUTY50_EN
    phase_next = ({1'b0, cnt_next} < (({1'b0, ratio_next} + (DIV_W+1)'(1)) >> 1));
`else
    phase_next = (cnt_next == '0) && (ratio_next >= MIN_R);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      shadow_q      <= MIN_R;
      clk_div_q     <= 1'b0;
      en_d_q        <= 1'b0;
      busy_q        <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      period_done_q <= (state_q != ST_IDLE) && wrap;
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_q   <= ST_RUN;
            clk_div_q <= phase_next;
            en_d_q    <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            clk_div_q <= 1'b0;
            en_d_q    <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        ST_RUN: begin
          // A stop on the last count has nothing left to drain.
          if (stop && wrap) begin
            state_q   <= ST_IDLE;
            clk_div_q <= 1'b0;
            en_d_q    <= 1'b0;
            busy_q    <= 1'b0;
          end else if (stop) begin
            state_q   <= ST_DRAIN;
            clk_div_q <= phase_next;
            en_d_q    <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            clk_div_q <= phase_next;
            en_d_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (wrap) begin
            state_q   <= ST_IDLE;
            clk_div_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            clk_div_q <= phase_next;
            busy_q    <= 1'b1;
          end
          en_d_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          clk_div_q <= 1'b0;
          en_d_q    <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign clk_div     = clk_div_q;
  assign en_d        = en_d_q;
  assign busy        = busy_q;
  assign period_done = period_done_q;
endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: a per-cycle vector table plus multi-cycle period sequences.
module tb_clk_div_gen;
  logic       clk = 1'b0;
  logic       reset, start, stop, load;
  logic [7:0] div_ratio;
  logic       clk_div, en_d, busy, period_done;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  clk_div_gen #(.DIV_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .load        (load),
    .div_ratio   (div_ratio),
    .clk_div     (clk_div),
    .en_d        (en_d),
    .busy        (busy),
    .period_done (period_done)
  );

  // exp is {clk_div, en_d, busy, period_done} after the edge that sampled the inputs
  typedef struct {
    logic       rst_n;
    logic       st;
    logic       sp;
    logic       ld;
    logic [7:0] ratio;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic p, input logic l, input logic [7:0] d);
    reset     = r;
    start     = s;
    stop      = p;
    load      = l;
    div_ratio = d;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {clk_div, en_d, busy, period_done};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: clk_div/en_d/busy/period_done got %b required %b", name, got, exp);
    end else begin
      $display("ok   %s: clk_div/en_d/busy/period_done = %b", name, got);
    end
  endtask

  function automatic logic exp_clk(input int c, input int n);
`ifdef CLK_DIV_GEN_DUTY50_EN
    return c < (n + 1) / 2;
`else
    return c == 0;
`endif
  endfunction

  initial begin
    int c, n;
    logic pd;
    int ns[3];
    //            rst  st   sp   ld   ratio  exp
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000}; // reset
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 4'b0000}; // start+stop: stop wins
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 4'b0000}; // load 0 -> divide by 2
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'b1110};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0110};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b1111};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0110};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b1111};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0010}; // stop at cnt0 -> drain
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0001}; // drain ends, done pulse
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd4, 4'b1110}; // load 4 with start
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd9, 4'b0000}; // reset mid-run N=4 wins
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'b1110}; // shadow back to 2
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0110};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b1111}; // wraps after 2, not 4
    vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 4'b0010};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0001};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst_n, vecs[i].st, vecs[i].sp, vecs[i].ld, vecs[i].ratio);
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // N=4 running, load 7 while cnt=1: this period stays 4, later ones are 7
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd4); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0); tick();
    check("reload_k0", {exp_clk(0, 4), 3'b110});
    for (int k = 1; k <= 18; k++) begin
      drive(1'b1, 1'b0, 1'b0, (k == 2), 8'd7);
      tick();
      if (k < 4) begin c = k; n = 4; end
      else begin c = (k - 4) % 7; n = 7; end
      pd = (c == 0);
      check($sformatf("reload_k%0d", k), {exp_clk(c, n), 1'b1, 1'b1, pd});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0); tick();
    check("reload_reset", 4'b0000);

    // N=5, stop while cnt=2: drain to period end, one done pulse, then idle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd5); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0); tick();
    check("drain_k0", {exp_clk(0, 5), 3'b110});
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b0, (k == 3), 1'b0, 8'd0);
      tick();
      if (k <= 4)      check($sformatf("drain_k%0d", k), {exp_clk(k, 5), (k < 3), 1'b1, 1'b0});
      else if (k == 5) check("drain_end", 4'b0001);
      else             check("drain_idle", 4'b0000);
    end

    // Steady-state waveform over two full periods for several ratios
    ns = '{6, 3, 2};
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'(ns[j])); tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0); tick();
      check($sformatf("wave%0d_k0", ns[j]), {exp_clk(0, ns[j]), 3'b110});
      for (int k = 1; k <= 2 * ns[j]; k++) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        c = k % ns[j];
        check($sformatf("wave%0d_k%0d", ns[j], k), {exp_clk(c, ns[j]), 1'b1, 1'b1, (c == 0)});
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0); tick();
      check($sformatf("wave%0d_reset", ns[j]), 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter: DIV_W, 8, width of division ratio and period counter.
REQ-002 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 Port: start  input  1  run request; single-cycle pulse expected.
REQ-005 Port: stop  input  1  stop request; single-cycle pulse expected.
REQ-006 Port: load  input  1  strobe capturing div_ratio into shadow register.
REQ-007 Port: div_ratio  input  DIV_W  requested period N in clk cycles.
REQ-008 Port: clk_div  output  1  registered divided clock-enable waveform; drives downstream edge-detecting counter.
REQ-009 Port: en_d  output  1  registered; 1 = downstream counter advances, 0 = downstream counter clears.
REQ-010 Port: busy  output  1  registered; high in RUN or DRAIN.
REQ-011 Port: period_done  output  1  registered single-cycle pulse at end of each period.

Function
REQ-012 FSM states: IDLE, RUN, DRAIN; encoding is free.
REQ-013 Effective ratio N = max(shadow, 2); shadow values 0 and 1 SHALL divide by 2.
REQ-014 Period counter cnt counts 0..N-1, wraps to 0; DIV_W bits, no overflow beyond N-1.
REQ-015 IDLE: start=1 and stop=0 -> RUN next cycle, cnt=0; clk_div first high in the first RUN cycle.
REQ-016 Start and stop in the same cycle: stop wins; start ignored in every state.
REQ-017 RUN: stop=1 -> DRAIN; current period completes unchanged.
REQ-018 DRAIN: at cnt=N-1 -> IDLE; cnt=0, clk_div=0 from first IDLE cycle.
REQ-019 period_done pulses for exactly one cycle, the cycle after cnt=N-1, in RUN or DRAIN.
REQ-020 en_d=1 in RUN only; 0 in IDLE and DRAIN.
REQ-021 load in IDLE: shadow updated next cycle, used by the next start.
REQ-022 load in RUN/DRAIN: shadow captured; new N takes effect at next wrap (cnt=N-1 -> 0), never mid-period.
REQ-023 Multiple loads within one period: last value wins.
REQ-024 clk_div is glitch-free, driven from a flop only.

Reset
REQ-025 reset=0 at a rising edge: state=IDLE, cnt=0, shadow=2, clk_div=0, en_d=0, busy=0, period_done=0.
REQ-026 Reset asserted mid-period overrides start, stop and load; no period_done is emitted for the aborted period.

Configuration
REQ-027 Macro CLK_DIV_GEN_DUTY50_EN defined: clk_div high for cnt in 0..ceil(N/2)-1, low for the rest; N=5 gives 3 high, 2 low.
REQ-028 Macro undefined: clk_div high only for cnt=0, a one-cycle pulse per period. Every other behaviour is identical.

Structure
REQ-029 Package clk_div_gen_pkg SHALL hold the FSM state typedef, the MIN_RATIO=2 constant and the default DIV_W.
REQ-030 One sub-module, clk_div_gen_period_cnt: counter with wrap flag and a shadow-ratio apply-on-wrap input. FSM and output flops stay in clk_div_gen.

Verification
REQ-031 Reset mid-RUN with N=4 -> next cycle all outputs 0, state IDLE, shadow=2.
REQ-032 load 6, start, DUTY50 defined -> clk_div repeats 3 high / 3 low; period_done every 6 cycles; en_d=1.
REQ-033 div_ratio=0, start -> divide by 2: clk_div alternates 1,0; period_done every 2 cycles.
REQ-034 N=4 RUN, load 7 at cnt=1 -> current period stays 4 cycles, following periods 7 cycles; no partial period.
REQ-035 N=5 RUN, stop at cnt=2 -> en_d=0 next cycle, busy held until period end, one period_done, then IDLE and clk_div=0.
REQ-036 start and stop in the same IDLE cycle -> stays IDLE, busy=0, clk_div=0; macro undefined with N=3 -> one-cycle clk_div pulse every 3 cycles.
